// File: rtl/hack_cpu_ctrl_if.sv
// rtl/hack_cpu_ctrl_if.sv - Hack CPU control bus: instruction fetch, data memory and ALU hookup
// master = control/register stage, slave = ROM/RAM/ALU side.
interface hack_cpu_ctrl_if #(
   parameter int PC_W = 15,
   parameter int DW   = 16
);
   logic [PC_W-1:0] pc;
   logic            instr_req;
   logic [DW-1:0]   instr;
   logic            instr_valid;
   logic [PC_W-1:0] dmem_addr;
   logic            dmem_rd;
   logic            dmem_wr;
   logic [DW-1:0]   dmem_wdata;
   logic [DW-1:0]   dmem_rdata;
   logic            dmem_ack;
   logic [DW-1:0]   alu_x;
   logic [DW-1:0]   alu_y;
   logic            alu_zx;
   logic            alu_nx;
   logic            alu_zy;
   logic            alu_ny;
   logic            alu_f;
   logic            alu_no;
   logic [DW-1:0]   alu_out;
   logic            alu_zr;
   logic            alu_ng;
   logic [DW-1:0]   a_reg;
   logic [DW-1:0]   d_reg;

   modport master (
      output pc, instr_req, dmem_addr, dmem_rd, dmem_wr, dmem_wdata,
      output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
      output a_reg, d_reg,
      input  instr, instr_valid, dmem_rdata, dmem_ack, alu_out, alu_zr, alu_ng
   );

   modport slave (
      input  pc, instr_req, dmem_addr, dmem_rd, dmem_wr, dmem_wdata,
      input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
      input  a_reg, d_reg,
      output instr, instr_valid, dmem_rdata, dmem_ack, alu_out, alu_zr, alu_ng
   );
endinterface

// File: rtl/hack_cpu_ctrl.sv
// rtl/hack_cpu_ctrl.sv - Multi-cycle Hack CPU control and register stage
// Fetch/decode/mem-read/exec/mem-write sequencer feeding an external combinational ALU.
module hack_cpu_ctrl #(
   parameter int PC_W = 15,
   parameter int DW   = 16
) (
   input  logic           clk,
   input  logic           reset,
   hack_cpu_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_MREAD  = 3'd2,
      S_EXEC   = 3'd3,
      S_MWRITE = 3'd4
   } state_e;

   state_e          state_q;
   logic [PC_W-1:0] pc_q;
   logic [DW-1:0]   a_q;
   logic [DW-1:0]   d_q;
   logic [DW-1:0]   ir_q;
   logic [DW-1:0]   m_q;
   logic            rd_q;
   logic            wr_q;
   logic [PC_W-1:0] addr_q;
   logic [DW-1:0]   wdata_q;

   logic [PC_W-1:0] pc_inc_d;
   logic            jump_d;

   assign pc_inc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
   assign jump_d   = (ir_q[2] & bus.alu_ng) | (ir_q[1] & bus.alu_zr) |
                     (ir_q[0] & ~bus.alu_ng & ~bus.alu_zr);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         a_q     <= '0;
         d_q     <= '0;
         ir_q    <= '0;
         m_q     <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (bus.instr_valid) begin
                  ir_q    <= bus.instr;
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (!ir_q[15]) begin
                  a_q     <= ir_q;
                  pc_q    <= pc_inc_d;
                  state_q <= S_FETCH;
               end else if (ir_q[12]) begin
                  rd_q    <= 1'b1;
                  addr_q  <= a_q[PC_W-1:0];
                  state_q <= S_MREAD;
               end else begin
                  state_q <= S_EXEC;
               end
            end
            S_MREAD: begin
               if (bus.dmem_ack) begin
                  m_q     <= bus.dmem_rdata;
                  rd_q    <= 1'b0;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               // a_q on the right-hand side is still the pre-instruction A for target/address.
               if (ir_q[5]) a_q <= bus.alu_out;
               if (ir_q[4]) d_q <= bus.alu_out;
               pc_q <= jump_d ? a_q[PC_W-1:0] : pc_inc_d;
               if (ir_q[3]) begin
                  addr_q  <= a_q[PC_W-1:0];
                  wdata_q <= bus.alu_out;
                  wr_q    <= 1'b1;
                  state_q <= S_MWRITE;
               end else begin
                  state_q <= S_FETCH;
               end
            end
            S_MWRITE: begin
               if (bus.dmem_ack) begin
                  wr_q    <= 1'b0;
                  state_q <= S_FETCH;
               end
            end
            default: state_q <= S_FETCH;
         endcase
      end
   end

   assign bus.pc         = pc_q;
   assign bus.instr_req  = (state_q == S_FETCH);
   assign bus.dmem_addr  = addr_q;
   assign bus.dmem_rd    = rd_q;
   assign bus.dmem_wr    = wr_q;
   assign bus.dmem_wdata = wdata_q;
   assign bus.alu_x      = d_q;
   assign bus.alu_y      = ir_q[12] ? m_q : a_q;
   assign bus.alu_zx     = ir_q[11];
   assign bus.alu_nx     = ir_q[10];
   assign bus.alu_zy     = ir_q[9];
   assign bus.alu_ny     = ir_q[8];
   assign bus.alu_f      = ir_q[7];
   assign bus.alu_no     = ir_q[6];
   assign bus.a_reg      = a_q;
   assign bus.d_reg      = d_q;
endmodule

// File: doc/hack_cpu_ctrl.md
Name: hack_cpu_ctrl

Overview:
- Multi-cycle Hack CPU control and register stage that sits directly upstream of the combinational ALU.
- Fetches instructions, decodes A/C instructions and drives the ALU operands and control bits.
- Consumes the ALU result and flags to update A, D and PC, and to evaluate jumps.
- Sequences data-memory reads and writes over a valid/ack handshake; instruction memory may stall via instr_valid.

Parameters:
- PC_W, 15, width of PC and memory addresses.
- DW, 16, data/instruction width.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- pc  out  PC_W  instruction address, stable for whole instruction
- instr_req  out  1  high in FETCH
- instr  in  DW  instruction word from ROM
- instr_valid  in  1  instr valid this cycle
- dmem_addr  out  PC_W  data address
- dmem_rd  out  1  read request
- dmem_wr  out  1  write request
- dmem_wdata  out  DW  write data
- dmem_rdata  in  DW  read data, valid with dmem_ack
- dmem_ack  in  1  completes the pending rd/wr
- alu_x  out  DW  D register
- alu_y  out  DW  A (a=0) or latched M (a=1)
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  IR[11], IR[10], IR[9], IR[8], IR[7], IR[6]
- alu_out  in  DW  ALU result
- alu_zr  in  1  result zero
- alu_ng  in  1  result negative
- a_reg  out  DW  A register (debug/observe)
- d_reg  out  DW  D register (debug/observe)

Behaviour:
- Reset (sync, high), from any state:
  - state=FETCH; pc=0; A=0; D=0; IR=0; Mreg=0.
  - dmem_rd=0, dmem_wr=0, dmem_wdata=0, dmem_addr=0.
  - Any in-flight memory transaction is abandoned; a late ack is ignored.
- States: FETCH, DECODE, MREAD, EXEC, MWRITE.
- FETCH:
  - instr_req=1.
  - When instr_valid=1, IR<=instr and go to DECODE; otherwise stay.
- DECODE:
  - IR[15]=0 (A-instruction): A<=IR (bit15 is 0), pc<=pc+1, go to FETCH. Total 2 cycles with zero ROM wait.
  - IR[15]=1, IR[12]=1: go to MREAD.
  - IR[15]=1, IR[12]=0: go to EXEC.
- MREAD:
  - dmem_rd=1, dmem_addr=A[PC_W-1:0].
  - Held until dmem_ack; on ack, Mreg<=dmem_rdata, dmem_rd drops the next cycle, go to EXEC.
- EXEC (ALU combinational, one cycle):
  - Capture Aold=A before any update.
  - d1 (IR[5]): A<=alu_out. d2 (IR[4]): D<=alu_out.
  - Jump: j1=IR[2] (alu_ng), j2=IR[1] (alu_zr), j3=IR[0] (~alu_ng & ~alu_zr). Any true -> pc<=Aold[PC_W-1:0], else pc<=pc+1.
  - d3 (IR[3]): latch waddr=Aold, dmem_wdata=alu_out, go to MWRITE. Otherwise go to FETCH.
- MWRITE:
  - dmem_wr=1, dmem_addr=waddr, dmem_wdata stable.
  - Held until dmem_ack, then dmem_wr=0 and go to FETCH.
  - pc already holds the next value.
- Address and operand rules:
  - M-write address and jump target always use A from before this instruction, even when d1 also writes A.
  - alu_y uses Mreg when IR[12]=1, else A.
- PC arithmetic: pc+1 wraps modulo 2^PC_W (0x7FFF -> 0).
- Handshake rules:
  - dmem_rd and dmem_wr are never high together.
  - Requests are asserted from the first cycle of the state.
  - ack while no request is pending is ignored.
  - ack in the same cycle the request rises is accepted.
- Latencies with zero wait: A-instr 2 cycles; C-instr 3; C with M read 4+; C with M write 4+; read+write 5+.

Test Plan:
- Reset; feed 0x0005 -> after 2 cycles A=5, pc=1, no dmem activity.
- @5 then 0xEC10 (D=A) -> alu_x=0, alu_y=5, zx..no=110000, D=5, pc=2.
- D=5; @100; 0xE308 (M=D), ack delayed 3 cycles -> dmem_wr high 4 cycles, dmem_addr=100, dmem_wdata=5; FETCH after ack; pc=4.
- @100; 0xFC10 (D=M), dmem_rdata=0x1234, ack after 2 cycles -> dmem_rd held, D=0x1234, alu_y=0x1234 in EXEC.
- @10; 0xE301 (D;JGT): with D=5 -> pc=10; with D=0 -> pc=pc+1; 0xEA87 (0;JMP) with A=0x7FFF -> pc=0x7FFF; next A-instr -> pc wraps to 0.
- Assert reset during MWRITE before ack -> next cycle dmem_wr=0, pc=0, A=D=0, state FETCH; a late ack causes no write.
